dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, the core presents a request.
REQ-006 SHALL have port req_ready, output, 1, the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, response available.
REQ-012 SHALL have port resp_ready, input, 1, the core accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32, load result, extended to 32 bits.
REQ-014 SHALL have port resp_err, output, 1, the request was rejected (misaligned, out of range, or illegal funct3).

Function
REQ-015 SHALL implement the states IDLE, BUSY and RESP; at most one request SHALL be outstanding.
REQ-016 SHALL drive req_ready = 1 only in IDLE; acceptance occurs when req_valid && req_ready are high at a clock edge.
REQ-017 SHALL register req_we, req_funct3, req_addr and req_wdata on acceptance; later input changes SHALL have no effect.
REQ-018 SHALL move IDLE->BUSY on acceptance and load a latency counter with LATENCY-1.
REQ-019 SHALL decrement the counter in BUSY and move BUSY->RESP when it is 0; resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge (LATENCY=1: the state passes through BUSY for one cycle only).
REQ-020 SHALL perform the array write and sample read data on the BUSY->RESP edge, so that a load accepted after a store returns the stored value.
REQ-021 SHALL, in RESP, hold resp_valid=1 and keep resp_rdata and resp_err stable until resp_ready=1, then return to IDLE on that edge; no new request SHALL be accepted on the same edge.
REQ-022 SHALL use word index addr[11:2] for DEPTH_WORDS=1024 (general: addr[log2(DEPTH_WORDS)+1:2]); any higher address bit set SHALL be flagged out of range.
REQ-023 SHALL flag as misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-024 SHALL treat as illegal funct3 011, 110 and 111 for loads, and any value other than 000/001/010 for stores.
REQ-025 SHALL, on any error, set resp_err=1 and resp_rdata=0 and leave the array unmodified.
REQ-026 SHALL, for SB, write only byte lane addr[1:0] with wdata[7:0]; for SH, only lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; for SW, all 4 lanes.
REQ-027 SHALL, for loads, select the byte or halfword at addr[1:0]; B and H SHALL sign-extend, BU and HU SHALL zero-extend, and W SHALL pass through unchanged.
REQ-028 SHALL return resp_rdata=0 and resp_err=0 for successful stores.
REQ-029 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, enter IDLE with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0.
REQ-031 SHALL, on reset during BUSY, discard the pending request; a store not yet performed SHALL NOT modify the array.
REQ-032 SHALL NOT clear array contents on reset.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF, then LW 0x10, LATENCY=2 -> resp_valid 2 cycles after each accept; load rdata=0xDEADBEEF, err=0.
REQ-034 SB addr 0x21 data 0x80 over word 0; LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; LW 0x20 -> 0x00008000.
REQ-035 SH addr 0x32 data 0x8001; LH 0x32 -> 0xFFFF8001; LHU 0x32 -> 0x00008001; LW 0x30 -> 0x80010000.
REQ-036 LW 0x13, SH 0x41, LW 0x1000 and load funct3=011 -> each err=1, rdata=0; no array change confirmed by LW readback.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 -> req_ready=0, response stable, no second accept; resp_ready=1 -> IDLE next cycle.
REQ-038 Assert reset in BUSY during SW 0x50 data 0x12345678 -> IDLE next cycle; a later LW 0x50 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port data-memory responder for a RISC-V core.
// One request at a time. A fixed LATENCY separates acceptance from the response,
// and the response is held until the core takes it.
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | request latched, latency counter running
// RESP  | response presented, waiting for resp_ready
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          finish;
  logic          illegal;
  logic          misalign;
  logic          out_of_range;
  logic          err;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_val;

  assign accept = (state == IDLE) && req_valid;
  assign finish = (state == BUSY) && (cnt == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request decode on the latched fields: error detection, lane enables, load extraction
  always_comb begin
    if (we_q) illegal = !(f3_q == 3'b000 || f3_q == 3'b001 || f3_q == 3'b010);
    else      illegal = (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111);
    misalign     = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    out_of_range = (addr_q >> (AW + 2)) != 32'd0;
    err          = illegal || misalign || out_of_range;
    idx          = addr_q[AW+1:2];

    be = 4'b0000;
    wd = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << {addr_q[1], 1'b0};
        wd = {2{wdata_q[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase

    word   = mem[idx];
    byte_v = 8'(word >> {addr_q[1:0], 3'b000});
    half_v = addr_q[1] ? word[31:16] : word[15:0];
    case (f3_q)
      3'b000:  ld_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_val = {{16{half_v[15]}}, half_v};
      3'b010:  ld_val = word;
      3'b100:  ld_val = {24'd0, byte_v};
      3'b101:  ld_val = {16'd0, half_v};
      default: ld_val = 32'd0;
    endcase
  end

  // Request capture, latency counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        err_q   <= err;
        rdata_q <= (err || we_q) ? 32'd0 : ld_val;
      end
    end
  end

  // Backing array: not reset, written only on a successful store as the response forms
  always_ff @(posedge clk) begin
    if (!reset && finish && we_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference model.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mb [4096];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: memory as bytes, access size from funct3, plain alignment arithmetic
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wdat, output logic [31:0] rd, output logic e);
    int sz;
    logic legal;
    logic [31:0] v;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f3[1:0];
    e  = !legal || ((a % sz) != 0) || (a >= 32'd4096);
    rd = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mb[int'(a) + i] = wdat[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(mb[int'(a) + i]) << (8*i));
        case (sz)
          1:       rd = f3[2] ? v : 32'($signed(v[7:0]));
          2:       rd = f3[2] ? v : 32'($signed(v[15:0]));
          default: rd = v;
        endcase
      end
    end
  endfunction

  // One full transaction; during `hold` cycles in RESP a competing request is presented
  task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wdat, input int hold);
    logic [31:0] exp_rd;
    logic        exp_e;
    logic [31:0] first_rd;
    logic        first_e;
    int          cyc;
    model(we, f3, a, wdat, exp_rd, exp_e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wdat;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (resp_valid) break;
      if (cyc == 1) check({tag, "_idle_out"}, resp_rdata | 32'(resp_err), 32'd0);
    end
    if (!resp_valid) begin
      check({tag, "_timeout"}, 32'(resp_valid), 32'd1);
      return;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(LAT));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_e));
    first_rd = resp_rdata;
    first_e  = resp_err;
    if (hold > 0) req_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {resp_rdata[30:0] ^ first_rd[30:0], resp_err ^ first_e},
            {31'd0, 1'b0} | 32'(resp_rdata[31] ^ first_rd[31]) << 31 ^ 32'd0);
      check({tag, "_hold_vr"}, {30'd0, resp_valid, req_ready}, 32'b10);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] ra;
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b0;

    for (int w = 0; w < 64; w++) do_txn("init", 1'b1, 3'b010, 32'(w * 4), 32'd0, 0);

    do_txn("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    do_txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0);
    do_txn("sb21", 1'b1, 3'b000, 32'h21, 32'h80, 0);
    do_txn("lb21", 1'b0, 3'b000, 32'h21, 32'h0, 0);
    do_txn("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 0);
    do_txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 0);
    do_txn("sh32", 1'b1, 3'b001, 32'h32, 32'h8001, 0);
    do_txn("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 0);
    do_txn("lhu32", 1'b0, 3'b101, 32'h32, 32'h0, 0);
    do_txn("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 0);
    do_txn("sw40", 1'b1, 3'b010, 32'h40, 32'hA5A5_5A5A, 0);
    do_txn("lw13", 1'b0, 3'b010, 32'h13, 32'h0, 0);
    do_txn("sh41", 1'b1, 3'b001, 32'h41, 32'hFFFF, 0);
    do_txn("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 0);
    do_txn("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 0);
    do_txn("sb_f3_4", 1'b1, 3'b100, 32'h40, 32'h0, 0);
    do_txn("lw40_rb", 1'b0, 3'b010, 32'h40, 32'h0, 0);
    do_txn("lw10_rb", 1'b0, 3'b010, 32'h10, 32'h0, 0);
    do_txn("hold5", 1'b0, 3'b010, 32'h10, 32'h0, 5);

    do_txn("sw50", 1'b1, 3'b010, 32'h50, 32'hCAFEF00D, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h50; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rstbusy_idle", {30'd0, resp_valid, req_ready}, 32'b01);
    repeat (3) @(posedge clk);
    #1;
    check("rstbusy_quiet", {30'd0, resp_valid, req_ready}, 32'b01);
    do_txn("lw50", 1'b0, 3'b010, 32'h50, 32'h0, 0);

    for (int n = 0; n < 250; n++) begin
      rwe = 1'($urandom);
      rf3 = 3'($urandom);
      if (($urandom % 10) == 0) ra = $urandom | 32'h1000;
      else                      ra = $urandom_range(0, 255);
      do_txn("rnd", rwe, rf3, ra, $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
